// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder on the cache-to-memory bus (C2/A2/D2).
//                Holds 2^ADDR2_BUS_SIZE lines and serves whole-line reads and
//                writes after a fixed latency. All activity is on negedge CLK.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA2_BUS_SIZE  = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int MEM_LATENCY     = 100
) (
  input  logic                      CLK,
  input  logic                      RESET,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2,
  input  logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2
);

  localparam int C_LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int C_BEATS     = C_LINE_BITS / DATA2_BUS_SIZE;
  localparam int C_DEPTH     = 1 << ADDR2_BUS_SIZE;
  localparam int C_CNT_W     = $clog2(MEM_LATENCY);
  localparam int C_BEAT_W    = $clog2(C_BEATS) + 1;

  localparam logic [C_CNT_W-1:0]       C_CNT_LAST  = C_CNT_W'(MEM_LATENCY - 1);
  localparam logic [C_BEAT_W-1:0]      C_BEAT_LAST = C_BEAT_W'(C_BEATS - 1);
  localparam logic [C_BEAT_W-1:0]      C_BEAT_END  = C_BEAT_W'(C_BEATS);
  localparam logic [CTR2_BUS_SIZE-1:0] C_RSP       = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C_CMD_RD    = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C_CMD_WR    = CTR2_BUS_SIZE'(3);

  // The write path needs all beats received before the commit edge.
  if (MEM_LATENCY < C_BEATS + 1) begin : g_latency_check
    $fatal(1, "mem_responder: MEM_LATENCY must be at least BEATS+1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_SEND = 3'd2,
    ST_WR_RECV = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_ACK  = 3'd5
  } state_t;

  state_t                      r_state;
  logic [C_CNT_W-1:0]          r_cnt;
  logic [C_BEAT_W-1:0]         r_beat;
  logic [ADDR2_BUS_SIZE-1:0]   r_addr;
  logic [C_LINE_BITS-1:0]      r_wbuf;
  logic [C_LINE_BITS-1:0]      r_line;
  logic                        r_c2_oe;
  logic [CTR2_BUS_SIZE-1:0]    r_c2;
  logic                        r_d2_oe;
  logic [DATA2_BUS_SIZE-1:0]   r_d2;
  logic [C_LINE_BITS-1:0]      r_mem [0:C_DEPTH-1];
  logic                        w_commit;

  // The bus is only driven while this side owns it.
  assign C2 = r_c2_oe ? r_c2 : {CTR2_BUS_SIZE{1'bz}};
  assign D2 = r_d2_oe ? r_d2 : {DATA2_BUS_SIZE{1'bz}};

  // A buffered write lands in the array only at its acknowledge edge.
  assign w_commit = (r_state == ST_WR_WAIT) && (r_cnt == C_CNT_LAST);

  // Array update; never reset so contents survive a RESET pulse.
  always_ff @(negedge CLK) begin
    if (w_commit) begin
      r_mem[r_addr] <= r_wbuf;
    end
  end

  // Transaction sequencer with registered bus drivers.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wbuf  <= '0;
      r_line  <= '0;
      r_c2_oe <= 1'b0;
      r_c2    <= '0;
      r_d2_oe <= 1'b0;
      r_d2    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (C2 === C_CMD_RD) begin
            r_addr  <= A2;
            r_cnt   <= '0;
            r_state <= ST_RD_WAIT;
          end else if (C2 === C_CMD_WR) begin
            r_addr                       <= A2;
            r_cnt                        <= '0;
            r_wbuf[0 +: DATA2_BUS_SIZE]  <= D2;
            r_beat                       <= C_BEAT_W'(1);
            r_state                      <= ST_WR_RECV;
          end
        end

        ST_RD_WAIT: begin
          if (r_cnt == C_CNT_LAST) begin
            r_line  <= r_mem[r_addr];
            r_d2    <= r_mem[r_addr][0 +: DATA2_BUS_SIZE];
            r_c2    <= C_RSP;
            r_c2_oe <= 1'b1;
            r_d2_oe <= 1'b1;
            r_beat  <= C_BEAT_W'(1);
            r_state <= ST_RD_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RD_SEND: begin
          if (r_beat == C_BEAT_END) begin
            r_c2_oe <= 1'b0;
            r_d2_oe <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_d2   <= r_line[r_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
            r_beat <= r_beat + 1'b1;
          end
        end

        ST_WR_RECV: begin
          r_wbuf[r_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] <= D2;
          r_cnt <= r_cnt + 1'b1;
          if (r_beat == C_BEAT_LAST) begin
            r_state <= ST_WR_WAIT;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end

        ST_WR_WAIT: begin
          if (w_commit) begin
            r_c2    <= C_RSP;
            r_c2_oe <= 1'b1;
            r_state <= ST_WR_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WR_ACK: begin
          r_c2_oe <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_c2_oe <= 1'b0;
          r_d2_oe <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Expected bus responses
//                are queued when commands are issued and matched cycle by
//                cycle against what appears on C2/D2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  localparam int LAT = 100;

  typedef struct {
    int          cyc;
    bit          wr;
    bit          last;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] a2 = '0;
  logic [1:0]  tb_c2 = '0;
  logic        tb_c2_oe = 1'b0;
  logic [15:0] tb_d2 = '0;
  logic        tb_d2_oe = 1'b0;
  wire  [1:0]  c2_bus;
  wire  [15:0] d2_bus;

  assign c2_bus = tb_c2_oe ? tb_c2 : 2'bzz;
  assign d2_bus = tb_d2_oe ? tb_d2 : 16'hzzzz;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  int   rel_at   = -1;
  exp_t exp_q[$];
  logic [255:0] model [int];

  mem_responder #(
    .ADDR2_BUS_SIZE (15),
    .DATA2_BUS_SIZE (16),
    .CTR2_BUS_SIZE  (2),
    .CACHE_LINE_SIZE(32),
    .MEM_LATENCY    (LAT)
  ) dut (
    .CLK  (clk),
    .RESET(reset_n),
    .C2   (c2_bus),
    .A2   (a2),
    .D2   (d2_bus)
  );

  always #5 clk = ~clk;

  // Count negedges; a command sampled on negedge k sees cyc==k afterwards.
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Undriven bus: 'z on a 4-state simulator, 0 on a 2-state one.
  function automatic logic released(input logic [15:0] v);
    return $isunknown(v) || (v === 16'h0000);
  endfunction

  function automatic logic [255:0] get_line(input int addr);
    if (model.exists(addr)) return model[addr];
    return '0;
  endfunction

  function automatic logic [255:0] make_line(input logic [15:0] base, input bit inc);
    logic [255:0] l;
    for (int i = 0; i < 16; i++) l[16*i +: 16] = inc ? base + 16'(i) : base;
    return l;
  endfunction

  // Response monitor: every C2==1 cycle must match the head of the queue.
  always @(posedge clk) begin
    exp_t it;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("resp_missing", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (c2_bus === 2'b01) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {30'd0, c2_bus}, 32'd0);
      end else begin
        it = exp_q.pop_front();
        check("resp_cycle", cyc, it.cyc);
        if (!it.wr) check("rd_beat", {16'd0, d2_bus}, {16'd0, it.data});
        if (it.last) rel_at = cyc + 1;
      end
    end
    if (cyc == rel_at) begin
      check("release_c2", {31'd0, released({14'd0, c2_bus})}, 32'd1);
      check("release_d2", {31'd0, released(d2_bus)}, 32'd1);
      rel_at = -1;
    end
  end

  task automatic do_write(input logic [14:0] addr, input logic [255:0] line);
    exp_t it;
    @(posedge clk); #1;
    it.cyc = cyc + 1 + LAT; it.wr = 1'b1; it.last = 1'b1; it.data = '0;
    exp_q.push_back(it);
    tb_c2 = 2'd3; tb_c2_oe = 1'b1; a2 = addr;
    tb_d2 = line[15:0]; tb_d2_oe = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      tb_c2_oe = 1'b0;
      tb_d2 = line[16*i +: 16];
    end
    @(posedge clk); #1;
    tb_d2_oe = 1'b0;
    model[int'(addr)] = line;
  endtask

  task automatic do_read(input logic [14:0] addr);
    exp_t         it;
    logic [255:0] line;
    int           k;
    line = get_line(int'(addr));
    @(posedge clk); #1;
    k = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      it.cyc = k + LAT + i; it.wr = 1'b0; it.last = (i == 15); it.data = line[16*i +: 16];
      exp_q.push_back(it);
    end
    tb_c2 = 2'd2; tb_c2_oe = 1'b1; a2 = addr;
    @(posedge clk); #1;
    tb_c2_oe = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_reset();
    exp_q.delete();
    rel_at = -1;
    reset_n = 1'b0;
    #1;
    check("rst_c2_release", {31'd0, released({14'd0, c2_bus})}, 32'd1);
    check("rst_d2_release", {31'd0, released(d2_bus)}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] abort_line;
    int           n;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle: nothing driven by the responder.
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_c2", {31'd0, released({14'd0, c2_bus})}, 32'd1);
      check("idle_d2", {31'd0, released(d2_bus)}, 32'd1);
    end

    // Write then read back incrementing pattern.
    do_write(15'h1234, make_line(16'hA500, 1'b1));
    drain();
    do_read(15'h1234);
    drain();

    // Last line never written reads zero; writing it does not alias line 0.
    do_read(15'h7FFF);
    drain();
    do_write(15'h7FFF, make_line(16'h5A00, 1'b1));
    drain();
    do_read(15'h0000);
    drain();
    do_read(15'h7FFF);
    drain();

    // Command during RD_WAIT is ignored.
    do_write(15'h0001, make_line(16'h0100, 1'b1));
    drain();
    do_write(15'h0002, make_line(16'h0200, 1'b1));
    drain();
    do_read(15'h0002);
    repeat (20) @(posedge clk);
    #1 tb_c2 = 2'd2; tb_c2_oe = 1'b1; a2 = 15'h0001;
    @(posedge clk); #1 tb_c2_oe = 1'b0;
    drain();

    // Reset in the middle of a read burst releases the bus.
    do_read(15'h1234);
    n = 0;
    while (exp_q.size() > 12 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("rd_abort_reach", {31'd0, exp_q.size() <= 12}, 32'd1);
    #2;
    pulse_reset();
    do_read(15'h1234);
    drain();

    // Reset at beat 8 of a write leaves the old line intact.
    do_write(15'h0042, make_line(16'h1111, 1'b0));
    drain();
    abort_line = make_line(16'hBEE0, 1'b1);
    @(posedge clk); #1;
    tb_c2 = 2'd3; tb_c2_oe = 1'b1; a2 = 15'h0042;
    tb_d2 = abort_line[15:0]; tb_d2_oe = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      tb_c2_oe = 1'b0;
      tb_d2 = abort_line[16*i +: 16];
    end
    #2;
    tb_d2_oe = 1'b0;
    pulse_reset();
    do_read(15'h0042);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache-to-memory bus (C2/A2/D2). It stores 2^ADDR2_BUS_SIZE lines of CACHE_LINE_SIZE bytes, which is 1 MiB at the defaults.
- It serves line reads (C2=2) and line writes (C2=3) issued by the cache, after a fixed access latency.
- It drives C2 and D2 only while it owns the bus.
- All bus sampling and driving happens on negedge CLK, matching the cache side.

Parameters:
- ADDR2_BUS_SIZE, 15: line-address width. The line index is A2, i.e. {tag,set}.
- DATA2_BUS_SIZE, 16: data bits per beat.
- CTR2_BUS_SIZE, 2: command/response width.
- CACHE_LINE_SIZE, 32: bytes per line. BEATS = CACHE_LINE_SIZE*8/DATA2_BUS_SIZE = 16.
- MEM_LATENCY, 100: cycles from command sample to first response edge. Must be >= BEATS+1; an elaboration check fails otherwise.

Ports:
- CLK  input  1  clock; all state changes on negedge.
- RESET  input  1  asynchronous, active-low reset.
- C2  inout  CTR2_BUS_SIZE  bus command/response. Encodings: 0 NOP, 1 RESPONSE, 2 READ_LINE, 3 WRITE_LINE. Driven 'z' when not owned.
- A2  input  ADDR2_BUS_SIZE  line address; valid in the command cycle only.
- D2  inout  DATA2_BUS_SIZE  line data beats; driven 'z' when not owned.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE; counters=0; C2 and D2 drivers = 'z'.
  - Memory array contents are retained; the array is zero at time 0.
  - Reset mid-transaction aborts it and releases the bus on the reset edge.
  - An aborted write leaves the array unchanged, because the write buffer is committed only at completion.
- Beat mapping: beat i carries line bits [DATA2_BUS_SIZE*i +: DATA2_BUS_SIZE]. The D2 numeric low byte = line byte 2i, high byte = byte 2i+1. Beat 0 goes first.
- States: IDLE, RD_WAIT, RD_SEND, WR_RECV, WR_WAIT, WR_ACK. The cycle counter cnt is cleared at the command sample.
- IDLE:
  - Sample C2 each negedge. Only C2===2 or C2===3 starts a transaction; 0, 1, x and z are ignored.
  - On a command, latch A2 into addr_q.
  - Read goes to RD_WAIT.
  - Write captures D2 as beat 0 into wbuf and goes to WR_RECV.
- RD_WAIT: count to MEM_LATENCY, then at negedge k+MEM_LATENCY (k = command edge):
  - drive C2=1 and D2=beat 0;
  - enter RD_SEND.
- RD_SEND:
  - Drive beats 1..BEATS-1 on the next BEATS-1 negedges, holding C2=1 throughout.
  - At negedge k+MEM_LATENCY+BEATS, release C2 and D2 to 'z' and return to IDLE.
  - The cache samples one beat per cycle while C2===1.
- WR_RECV:
  - Capture beats 1..BEATS-1 from D2 on negedges k+1..k+BEATS-1. The C2 value is ignored here (the cache releases it to 'z').
  - Then go to WR_WAIT.
- WR_WAIT:
  - At negedge k+MEM_LATENCY, commit wbuf to mem[addr_q] and drive C2=1; go to WR_ACK.
  - At the next negedge, release C2 to 'z' and return to IDLE.
  - The cache drives C2=0 one cycle later.
- Busy rules:
  - No new command is accepted outside IDLE; commands arriving while busy are ignored with no queueing.
  - The responder never drives D2 in write states.
- Read-after-write: a read of the same line issued after WR_ACK returns the newly committed data.
- Address: all 2^ADDR2_BUS_SIZE indices are valid with no wrap. Index 0x7FFF is the last line; index 0x0000 is distinct from it.
- Latency is exact. Response edge = command edge + MEM_LATENCY for both read and write, independent of data.

Test Plan:
- Reset, then idle 5 cycles with C2=0 → C2 and D2 read 'z' throughout; no C2=1 ever appears.
- Write line to A2=0x1234 with beats i → 16'hA500+i (command C2=3 at edge k) → C2===1 exactly at k+100 for one cycle, 'z' at k+101.
- Read A2=0x1234, command at edge m → C2=1 from m+100 to m+115 with D2=16'hA500+i on beat i; 'z' at m+116.
- Read never-written line 0x7FFF → 16 beats of 0. Write 0x7FFF, then read 0x0000 → still zeros (no aliasing).
- Issue C2=2 to 0x0001 during RD_WAIT of an earlier read to 0x0002 → ignored; only the 0x0002 response occurs, on schedule.
- Assert RESET=0 at beat 8 of a write to 0x0042 (previous content 0x1111 in all beats) → C2/D2 'z' immediately; a later read of 0x0042 returns 0x1111 in all beats.
